// File: rtl/rv_ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I controller:
// FSM states, opcodes, ALU/immediate/mux select codes.
package rv_ctrl_pkg;

   typedef enum logic [3:0] {
      FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR,
      EXR, EXI, ALUWB, BRANCH, JAL, JALR, JALR_LINK
   } state_t;

   localparam logic [6:0] OP_R    = 7'b0110011;
   localparam logic [6:0] OP_I    = 7'b0010011;
   localparam logic [6:0] OP_LW   = 7'b0000011;
   localparam logic [6:0] OP_SW   = 7'b0100011;
   localparam logic [6:0] OP_BR   = 7'b1100011;
   localparam logic [6:0] OP_JAL  = 7'b1101111;
   localparam logic [6:0] OP_JALR = 7'b1100111;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;
   localparam logic [2:0] ALU_XOR = 3'b100;
   localparam logic [2:0] ALU_SLT = 3'b101;
   localparam logic [2:0] ALU_SLL = 3'b110;
   localparam logic [2:0] ALU_SRL = 3'b111;

   localparam logic [2:0] IMM_I = 3'b000;
   localparam logic [2:0] IMM_S = 3'b001;
   localparam logic [2:0] IMM_B = 3'b010;
   localparam logic [2:0] IMM_U = 3'b011;
   localparam logic [2:0] IMM_J = 3'b100;

   localparam logic [1:0] SRCA_PC    = 2'b00;
   localparam logic [1:0] SRCA_OLDPC = 2'b01;
   localparam logic [1:0] SRCA_RS1   = 2'b10;

   localparam logic [1:0] SRCB_RS2  = 2'b00;
   localparam logic [1:0] SRCB_IMM  = 2'b01;
   localparam logic [1:0] SRCB_FOUR = 2'b10;

   localparam logic [1:0] RES_ALUOUT    = 2'b00;
   localparam logic [1:0] RES_DATA      = 2'b01;
   localparam logic [1:0] RES_ALURESULT = 2'b10;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   localparam logic [2:0] F3_LWSW = 3'b010;
   localparam logic [2:0] F3_BEQ  = 3'b000;
   localparam logic [2:0] F3_BNE  = 3'b001;

   function automatic logic [2:0] imm_src(input logic [6:0] op);
      case (op)
         OP_SW:   return IMM_S;
         OP_BR:   return IMM_B;
         OP_JAL:  return IMM_J;
         default: return IMM_I;
      endcase
   endfunction

endpackage

// File: rtl/multicycle_controller_if.sv
// Handshake between the controller and the unified
// instruction/data memory.
interface multicycle_controller_if;
   logic mem_req;
   logic MemWrite;
   logic AdrSrc;
   logic mem_ready;

   modport master (
      output mem_req, MemWrite, AdrSrc,
      input  mem_ready
   );

   modport slave (
      input  mem_req, MemWrite, AdrSrc,
      output mem_ready
   );
endinterface

// File: rtl/multicycle_controller_alu_decoder.sv
// ALU operation decode from ALUOp and the instruction
// function fields; flags encodings the ALU cannot execute.
module alu_decoder
   import rv_ctrl_pkg::*;
(
   input  logic [1:0] alu_op,
   input  logic [2:0] funct3,
   input  logic       funct7b5,
   input  logic       op5,
   output logic [2:0] alu_control,
   output logic       illegal
);

   always_comb begin
      alu_control = ALU_ADD;
      illegal     = 1'b0;
      unique case (alu_op)
         ALUOP_ADD: alu_control = ALU_ADD;
         ALUOP_SUB: alu_control = ALU_SUB;
         default: begin
            unique case (funct3)
               3'b000: alu_control = (op5 & funct7b5) ? ALU_SUB : ALU_ADD;
               3'b001: alu_control = ALU_SLL;
               3'b010: alu_control = ALU_SLT;
               3'b011: illegal = 1'b1;
               3'b100: alu_control = ALU_XOR;
               // arithmetic right shift has no ALU encoding
               3'b101: begin
                  if (funct7b5) illegal = 1'b1;
                  else alu_control = ALU_SRL;
               end
               3'b110: alu_control = ALU_OR;
               3'b111: alu_control = ALU_AND;
            endcase
         end
      endcase
   end

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle RV32I control FSM: state register, next-state
// logic and per-state datapath control decode.
module multicycle_controller
   import rv_ctrl_pkg::*;
(
   input  logic                     clk,
   input  logic                     rst,
   input  logic [6:0]               op,
   input  logic [2:0]               funct3,
   input  logic                     funct7b5,
   input  logic                     Zero,
   multicycle_controller_if.master  mem,
   output logic                     IRWrite,
   output logic                     PCWrite,
   output logic                     RegWrite,
   output logic [1:0]               ALUSrcA,
   output logic [1:0]               ALUSrcB,
   output logic [1:0]               ResultSrc,
   output logic [2:0]               ImmSrc,
   output logic [2:0]               ALUControl,
   output logic                     illegal
);

   state_t     state, next_state;
   logic [1:0] alu_op;
   logic [2:0] dec_ctrl;
   logic       dec_illegal;

   always_ff @(posedge clk) begin
      if (rst) state <= FETCH;
      else     state <= next_state;
   end

   always_comb begin
      alu_op = ALUOP_ADD;
      unique case (state)
         EXR, EXI: alu_op = ALUOP_FUNCT;
         BRANCH:   alu_op = ALUOP_SUB;
         default:  alu_op = ALUOP_ADD;
      endcase
   end

   alu_decoder u_alu_decoder (
      .alu_op      (alu_op),
      .funct3      (funct3),
      .funct7b5    (funct7b5),
      .op5         (op[5]),
      .alu_control (dec_ctrl),
      .illegal     (dec_illegal)
   );

   always_comb begin
      next_state   = state;
      mem.mem_req  = 1'b0;
      mem.MemWrite = 1'b0;
      mem.AdrSrc   = 1'b0;
      IRWrite      = 1'b0;
      PCWrite      = 1'b0;
      RegWrite     = 1'b0;
      ALUSrcA      = SRCA_PC;
      ALUSrcB      = SRCB_RS2;
      ResultSrc    = RES_ALUOUT;
      ImmSrc       = imm_src(op);
      ALUControl   = dec_ctrl;
      illegal      = 1'b0;
      unique case (state)
         FETCH: begin
            mem.mem_req = 1'b1;
            if (mem.mem_ready) begin
               IRWrite    = 1'b1;
               PCWrite    = 1'b1;
               ALUSrcB    = SRCB_FOUR;
               ResultSrc  = RES_ALURESULT;
               next_state = DECODE;
            end
         end
         DECODE: begin
            ALUSrcA = SRCA_OLDPC;
            ALUSrcB = SRCB_IMM;
            case (op)
               OP_R:         next_state = EXR;
               OP_I:         next_state = EXI;
               OP_LW, OP_SW: next_state = MEMADR;
               OP_BR:        next_state = BRANCH;
               OP_JAL:       next_state = JAL;
               OP_JALR:      next_state = JALR;
               default: begin
                  illegal    = 1'b1;
                  next_state = FETCH;
               end
            endcase
         end
         MEMADR: begin
            ALUSrcA = SRCA_RS1;
            ALUSrcB = SRCB_IMM;
            if (funct3 != F3_LWSW) begin
               illegal    = 1'b1;
               next_state = FETCH;
            end else begin
               next_state = op[5] ? MEMWR : MEMRD;
            end
         end
         MEMRD: begin
            mem.mem_req = 1'b1;
            mem.AdrSrc  = 1'b1;
            if (mem.mem_ready) next_state = MEMWB;
         end
         MEMWB: begin
            ResultSrc  = RES_DATA;
            RegWrite   = 1'b1;
            next_state = FETCH;
         end
         MEMWR: begin
            mem.mem_req  = 1'b1;
            mem.MemWrite = 1'b1;
            mem.AdrSrc   = 1'b1;
            if (mem.mem_ready) next_state = FETCH;
         end
         EXR, EXI: begin
            ALUSrcA = SRCA_RS1;
            ALUSrcB = (state == EXI) ? SRCB_IMM : SRCB_RS2;
            illegal = dec_illegal;
            next_state = dec_illegal ? FETCH : ALUWB;
         end
         ALUWB: begin
            RegWrite   = 1'b1;
            next_state = FETCH;
         end
         BRANCH: begin
            ALUSrcA = SRCA_RS1;
            unique case (1'b1)
               funct3 == F3_BEQ: PCWrite = Zero;
               funct3 == F3_BNE: PCWrite = !Zero;
               default:          illegal = 1'b1;
            endcase
            next_state = FETCH;
         end
         JAL: begin
            PCWrite    = 1'b1;
            ALUSrcA    = SRCA_OLDPC;
            ALUSrcB    = SRCB_FOUR;
            next_state = ALUWB;
         end
         JALR: begin
            ALUSrcA    = SRCA_RS1;
            ALUSrcB    = SRCB_IMM;
            ResultSrc  = RES_ALURESULT;
            PCWrite    = 1'b1;
            next_state = JALR_LINK;
         end
         JALR_LINK: begin
            ALUSrcA    = SRCA_OLDPC;
            ALUSrcB    = SRCB_FOUR;
            next_state = ALUWB;
         end
         default: next_state = FETCH;
      endcase
      // reset masks every output so an aborted instruction writes nothing
      if (rst) begin
         mem.mem_req  = 1'b0;
         mem.MemWrite = 1'b0;
         mem.AdrSrc   = 1'b0;
         IRWrite      = 1'b0;
         PCWrite      = 1'b0;
         RegWrite     = 1'b0;
         ALUSrcA      = 2'b00;
         ALUSrcB      = 2'b00;
         ResultSrc    = 2'b00;
         ImmSrc       = 3'b000;
         ALUControl   = 3'b000;
         illegal      = 1'b0;
      end
   end

endmodule
